alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one combinational integer ALU between two requesters.
  - Requester 0 is the execute stage.
  - Requester 1 is the address/aux unit.
- Valid/ready request handshake; arbitration is round-robin or fixed priority.
- ALU output is captured into a one-entry response buffer per requester, with valid/ready backpressure.
- Sits between the issue logic and the ALU instance; the ALU itself is external and driven through the alu_* ports.

Parameters:
- XLEN, 32, operand/result width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins conflicts.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rq0_valid  in  1  requester 0 request valid
- rq0_ready  out  1  requester 0 request accepted this cycle
- rq0_op, rq0_op_imm  in  1 each  ALU opcode class bits
- rq0_funct3  in  3  ALU funct3
- rq0_funct7  in  7  ALU funct7
- rq0_a, rq0_b  in  XLEN each  operands
- rs0_valid  out  1  requester 0 result valid
- rs0_ready  in  1  requester 0 consumes result
- rs0_data  out  XLEN  requester 0 result
- rq1_* / rs1_*  same set as above, for requester 1
- alu_op, alu_op_imm  out  1 each  to ALU
- alu_funct3  out  3  to ALU
- alu_funct7  out  7  to ALU
- alu_a, alu_b  out  XLEN each  to ALU
- alu_t  in  XLEN  ALU result, combinational

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - rs0_valid = rs1_valid = 0.
  - rs0_data = rs1_data = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first conflict.
  - All alu_* outputs = 0 while no grant.
- A request in flight is dropped on reset: if rst is asserted during the acceptance cycle, no response is produced.
- Slot free (per requester i): slot_free_i = !rsi_valid || rsi_ready. Draining and refilling in the same cycle is allowed.
- Eligibility: eligible_i = rqi_valid && slot_free_i.
- Grant, combinational, at most one per cycle:
  - Only one eligible → grant it.
  - Both eligible, FIXED_PRIO=1 → grant 0.
  - Both eligible, FIXED_PRIO=0 → grant the requester != last.
  - rqi_ready = grant_i, purely from eligibility; no dependency on rqi_ready itself.
- ALU drive: alu_* = fields of the granted request; all zeros when there is no grant.
- Capture: at a posedge with grant_i, rsi_data <= alu_t and rsi_valid <= 1.
  - If that is a round-robin conflict cycle, last <= i.
  - last updates on every grant, not only on conflicts.
- Drain: at a posedge with rsi_valid && rsi_ready && !grant_i, rsi_valid <= 0.
- Latency: request accepted in cycle N → rsi_valid in cycle N+1.
  - Back-to-back throughput is 1 op/cycle per requester while rsi_ready stays high.
- Stability: rsi_data and rsi_valid hold while rsi_valid && !rsi_ready. The loser's rq fields must be held by the requester (valid/ready rule: valid stays high until ready).
- No combinational path from alu_t to any rs* output; all rs* outputs come from registers.
- The ungranted requester's ready is 0 in the same cycle; it is never starved in round-robin mode. Worst-case wait is 1 cycle when its slot is free.
- ALU output of x (undefined funct7) is captured as-is; no checking here.

Optional Feature:
- Macro ALU_SHARE_ARB_STATS_EN adds outputs:
  - stat_grant0, stat_grant1  out  32 each  grant counts
  - stat_conflict  out  32  count of cycles with both rqi_valid=1 and exactly one granted
- Counters reset to 0, increment by 1 per event, and wrap from 32'hFFFFFFFF to 0.
- Without the macro, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request:
  - Stimulus: rq0 ADD (funct3=000, funct7=0) a=5, b=3; rs0_ready=1.
  - Response: rq0_ready=1 in cycle N; rs0_valid=1, rs0_data=8 in N+1; rs0_valid=0 in N+2.
- Round-robin conflict, FIXED_PRIO=0:
  - Stimulus: both valid from reset, rq0 SUB (funct7=0100000) 10-4, rq1 XOR 0xF0^0x0F.
  - Response: cycle N grants rq0 (rs0_data=6 at N+1); N+1 grants rq1 (rs1_data=0xFF at N+2).
  - Continued dual traffic alternates 0,1,0,1.
- Fixed priority, FIXED_PRIO=1:
  - Stimulus: both requesters valid continuously for 4 cycles.
  - Response: only rq0 granted; rq1_ready=0 throughout; rq1 granted the cycle after rq0_valid drops.
- Backpressure:
  - Stimulus: rs0_ready=0; rq0 issues 7+1 then SLT(-1,1).
  - Response: rs0_data=8 held; second request rq0_ready=0 until rs0_ready=1.
  - In the rs0_ready=1 cycle the second request is granted; next cycle rs0_data=1 with no bubble.
- Reset mid-operation:
  - Stimulus: assert rst in the same cycle rq1 is granted SRA(0x80000000,4).
  - Response: next cycle rs1_valid=0, rs1_data=0, last=1.
- Stats (ALU_SHARE_ARB_STATS_EN):
  - Stimulus: 3 conflict cycles under round-robin.
  - Response: stat_conflict=3, stat_grant0=2, stat_grant1=1.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// rtl/alu_share_arb_if.sv - request/response/ALU bus between issue logic, arbiter and shared ALU
interface alu_share_arb_if #(
    parameter int XLEN = 32
);
    logic            rq0_valid;
    logic            rq0_ready;
    logic            rq0_op;
    logic            rq0_op_imm;
    logic [2:0]      rq0_funct3;
    logic [6:0]      rq0_funct7;
    logic [XLEN-1:0] rq0_a;
    logic [XLEN-1:0] rq0_b;
    logic            rs0_valid;
    logic            rs0_ready;
    logic [XLEN-1:0] rs0_data;

    logic            rq1_valid;
    logic            rq1_ready;
    logic            rq1_op;
    logic            rq1_op_imm;
    logic [2:0]      rq1_funct3;
    logic [6:0]      rq1_funct7;
    logic [XLEN-1:0] rq1_a;
    logic [XLEN-1:0] rq1_b;
    logic            rs1_valid;
    logic            rs1_ready;
    logic [XLEN-1:0] rs1_data;

    logic            alu_op;
    logic            alu_op_imm;
    logic [2:0]      alu_funct3;
    logic [6:0]      alu_funct7;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_t;

    // arbiter side
    modport slave (
        input  rq0_valid, rq0_op, rq0_op_imm, rq0_funct3, rq0_funct7, rq0_a, rq0_b, rs0_ready,
        input  rq1_valid, rq1_op, rq1_op_imm, rq1_funct3, rq1_funct7, rq1_a, rq1_b, rs1_ready,
        input  alu_t,
        output rq0_ready, rs0_valid, rs0_data,
        output rq1_ready, rs1_valid, rs1_data,
        output alu_op, alu_op_imm, alu_funct3, alu_funct7, alu_a, alu_b
    );

    // issue logic plus ALU side
    modport master (
        output rq0_valid, rq0_op, rq0_op_imm, rq0_funct3, rq0_funct7, rq0_a, rq0_b, rs0_ready,
        output rq1_valid, rq1_op, rq1_op_imm, rq1_funct3, rq1_funct7, rq1_a, rq1_b, rs1_ready,
        output alu_t,
        input  rq0_ready, rs0_valid, rs0_data,
        input  rq1_ready, rs1_valid, rs1_data,
        input  alu_op, alu_op_imm, alu_funct3, alu_funct7, alu_a, alu_b
    );
endinterface

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - shares one combinational ALU between two requesters; optional counters via ALU_SHARE_ARB_STATS_EN
module alu_share_arb #(
    parameter int XLEN       = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    alu_share_arb_if.slave  bus
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    output logic [31:0]     stat_grant0,
    output logic [31:0]     stat_grant1,
    output logic [31:0]     stat_conflict
`endif
);

    logic            rs0_valid_q, rs0_valid_d;
    logic            rs1_valid_q, rs1_valid_d;
    logic [XLEN-1:0] rs0_data_q,  rs0_data_d;
    logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
    // last_q names the requester granted most recently; 1 after reset so requester 0 wins first
    logic            last_q,      last_d;

    logic            elig0, elig1;
    logic            grant0, grant1;

    // eligibility and grant: a requester competes only when its response slot can take a result
    always_comb begin
        elig0  = bus.rq0_valid && (!rs0_valid_q || bus.rs0_ready);
        elig1  = bus.rq1_valid && (!rs1_valid_q || bus.rs1_ready);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            if (FIXED_PRIO || last_q) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    // steer the granted request onto the ALU; idle bus is all zeros
    always_comb begin
        bus.alu_op     = 1'b0;
        bus.alu_op_imm = 1'b0;
        bus.alu_funct3 = 3'd0;
        bus.alu_funct7 = 7'd0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        if (grant0) begin
            bus.alu_op     = bus.rq0_op;
            bus.alu_op_imm = bus.rq0_op_imm;
            bus.alu_funct3 = bus.rq0_funct3;
            bus.alu_funct7 = bus.rq0_funct7;
            bus.alu_a      = bus.rq0_a;
            bus.alu_b      = bus.rq0_b;
        end else if (grant1) begin
            bus.alu_op     = bus.rq1_op;
            bus.alu_op_imm = bus.rq1_op_imm;
            bus.alu_funct3 = bus.rq1_funct3;
            bus.alu_funct7 = bus.rq1_funct7;
            bus.alu_a      = bus.rq1_a;
            bus.alu_b      = bus.rq1_b;
        end
    end

    // response slots: capture on grant (refill wins over drain), otherwise drain on consume
    always_comb begin
        rs0_valid_d = rs0_valid_q;
        rs0_data_d  = rs0_data_q;
        rs1_valid_d = rs1_valid_q;
        rs1_data_d  = rs1_data_q;
        last_d      = last_q;
        if (grant0) begin
            rs0_valid_d = 1'b1;
            rs0_data_d  = bus.alu_t;
            last_d      = 1'b0;
        end else if (rs0_valid_q && bus.rs0_ready) begin
            rs0_valid_d = 1'b0;
        end
        if (grant1) begin
            rs1_valid_d = 1'b1;
            rs1_data_d  = bus.alu_t;
            last_d      = 1'b1;
        end else if (rs1_valid_q && bus.rs1_ready) begin
            rs1_valid_d = 1'b0;
        end
    end

    // state registers; reset also discards a request accepted in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rs0_valid_q <= 1'b0;
            rs0_data_q  <= '0;
            rs1_valid_q <= 1'b0;
            rs1_data_q  <= '0;
            last_q      <= 1'b1;
        end else begin
            rs0_valid_q <= rs0_valid_d;
            rs0_data_q  <= rs0_data_d;
            rs1_valid_q <= rs1_valid_d;
            rs1_data_q  <= rs1_data_d;
            last_q      <= last_d;
        end
    end

    assign bus.rq0_ready = grant0;
    assign bus.rq1_ready = grant1;
    assign bus.rs0_valid = rs0_valid_q;
    assign bus.rs0_data  = rs0_data_q;
    assign bus.rs1_valid = rs1_valid_q;
    assign bus.rs1_data  = rs1_data_q;

`ifdef ALU_SHARE_ARB_STATS_EN
    logic [31:0] stat_grant0_q;
    logic [31:0] stat_grant1_q;
    logic [31:0] stat_conflict_q;

    // event counters; conflict means both asked and one was served, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0_q   <= 32'd0;
            stat_grant1_q   <= 32'd0;
            stat_conflict_q <= 32'd0;
        end else begin
            if (grant0) begin
                stat_grant0_q <= stat_grant0_q + 32'd1;
            end
            if (grant1) begin
                stat_grant1_q <= stat_grant1_q + 32'd1;
            end
            if (bus.rq0_valid && bus.rq1_valid && (grant0 || grant1)) begin
                stat_conflict_q <= stat_conflict_q + 32'd1;
            end
        end
    end

    assign stat_grant0   = stat_grant0_q;
    assign stat_grant1   = stat_grant1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - bench for alu_share_arb: round-robin and fixed-priority instances on shared stimulus
module tb_alu_share_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        in_rst;
    logic        in_v[2];
    logic        in_r[2];
    logic        in_op[2];
    logic        in_opi[2];
    logic [2:0]  in_f3[2];
    logic [6:0]  in_f7[2];
    logic [31:0] in_a[2];
    logic [31:0] in_b[2];

    int n_chk = 0;
    int n_err = 0;

    // environment ALU (RV32 integer register ops)
    function automatic logic [31:0] alu_fn(logic [2:0] f3, logic [6:0] f7, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0:    return f7[5] ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'd0, $signed(a) < $signed(b)};
            3'd3:    return {31'd0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    alu_share_arb_if #(.XLEN(32)) bus_rr ();
    alu_share_arb_if #(.XLEN(32)) bus_fp ();

    assign bus_rr.rq0_valid = in_v[0];   assign bus_fp.rq0_valid = in_v[0];
    assign bus_rr.rq0_op = in_op[0];     assign bus_fp.rq0_op = in_op[0];
    assign bus_rr.rq0_op_imm = in_opi[0]; assign bus_fp.rq0_op_imm = in_opi[0];
    assign bus_rr.rq0_funct3 = in_f3[0]; assign bus_fp.rq0_funct3 = in_f3[0];
    assign bus_rr.rq0_funct7 = in_f7[0]; assign bus_fp.rq0_funct7 = in_f7[0];
    assign bus_rr.rq0_a = in_a[0];       assign bus_fp.rq0_a = in_a[0];
    assign bus_rr.rq0_b = in_b[0];       assign bus_fp.rq0_b = in_b[0];
    assign bus_rr.rs0_ready = in_r[0];   assign bus_fp.rs0_ready = in_r[0];
    assign bus_rr.rq1_valid = in_v[1];   assign bus_fp.rq1_valid = in_v[1];
    assign bus_rr.rq1_op = in_op[1];     assign bus_fp.rq1_op = in_op[1];
    assign bus_rr.rq1_op_imm = in_opi[1]; assign bus_fp.rq1_op_imm = in_opi[1];
    assign bus_rr.rq1_funct3 = in_f3[1]; assign bus_fp.rq1_funct3 = in_f3[1];
    assign bus_rr.rq1_funct7 = in_f7[1]; assign bus_fp.rq1_funct7 = in_f7[1];
    assign bus_rr.rq1_a = in_a[1];       assign bus_fp.rq1_a = in_a[1];
    assign bus_rr.rq1_b = in_b[1];       assign bus_fp.rq1_b = in_b[1];
    assign bus_rr.rs1_ready = in_r[1];   assign bus_fp.rs1_ready = in_r[1];
    assign bus_rr.alu_t = alu_fn(bus_rr.alu_funct3, bus_rr.alu_funct7, bus_rr.alu_a, bus_rr.alu_b);
    assign bus_fp.alu_t = alu_fn(bus_fp.alu_funct3, bus_fp.alu_funct7, bus_fp.alu_a, bus_fp.alu_b);

`ifdef ALU_SHARE_ARB_STATS_EN
    logic [31:0] st_g0[2];
    logic [31:0] st_g1[2];
    logic [31:0] st_cf[2];
`endif

    alu_share_arb #(.XLEN(32), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(in_rst), .bus(bus_rr)
`ifdef ALU_SHARE_ARB_STATS_EN
        , .stat_grant0(st_g0[0]), .stat_grant1(st_g1[0]), .stat_conflict(st_cf[0])
`endif
    );

    alu_share_arb #(.XLEN(32), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(in_rst), .bus(bus_fp)
`ifdef ALU_SHARE_ARB_STATS_EN
        , .stat_grant0(st_g0[1]), .stat_grant1(st_g1[1]), .stat_conflict(st_cf[1])
`endif
    );

    logic [1:0]  o_rdy[2];
    logic [1:0]  o_rsv[2];
    logic [31:0] o_rsd[2][2];
    logic [75:0] o_alu[2];
    assign o_rdy[0] = {bus_rr.rq1_ready, bus_rr.rq0_ready};
    assign o_rdy[1] = {bus_fp.rq1_ready, bus_fp.rq0_ready};
    assign o_rsv[0] = {bus_rr.rs1_valid, bus_rr.rs0_valid};
    assign o_rsv[1] = {bus_fp.rs1_valid, bus_fp.rs0_valid};
    assign o_rsd[0][0] = bus_rr.rs0_data;
    assign o_rsd[0][1] = bus_rr.rs1_data;
    assign o_rsd[1][0] = bus_fp.rs0_data;
    assign o_rsd[1][1] = bus_fp.rs1_data;
    assign o_alu[0] = {bus_rr.alu_op, bus_rr.alu_op_imm, bus_rr.alu_funct3, bus_rr.alu_funct7, bus_rr.alu_a, bus_rr.alu_b};
    assign o_alu[1] = {bus_fp.alu_op, bus_fp.alu_op_imm, bus_fp.alu_funct3, bus_fp.alu_funct7, bus_fp.alu_a, bus_fp.alu_b};

    // reference model: per instance, two response slots, the last winner, and event counts
    bit          m_v[2][2];
    logic [31:0] m_d[2][2];
    bit          m_last[2];
    int          m_win[2];
    int unsigned m_cnt[2][3];
    logic [1:0]  s_rdy[2];

    task automatic chk(string name, int id, logic [75:0] act, logic [75:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %h want %h", name, id, act, exp);
        end
    endtask

    function automatic void model_reset(int k);
        for (int i = 0; i < 2; i++) begin
            m_v[k][i] = 1'b0;
            m_d[k][i] = 32'd0;
        end
        m_last[k] = 1'b1;
        for (int c = 0; c < 3; c++) m_cnt[k][c] = 0;
    endfunction

    // instance 1 is fixed priority; round-robin picks whoever did not win last
    function automatic int model_grant(int k);
        bit e0, e1;
        e0 = in_v[0] && (!m_v[k][0] || in_r[0]);
        e1 = in_v[1] && (!m_v[k][1] || in_r[1]);
        if (e0 && e1) return (k == 1) ? 0 : (m_last[k] ? 0 : 1);
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    function automatic void model_update(int k);
        int w;
        w = m_win[k];
        if (in_rst) begin
            model_reset(k);
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (w == i) begin
                m_v[k][i] = 1'b1;
                m_d[k][i] = alu_fn(in_f3[i], in_f7[i], in_a[i], in_b[i]);
            end else if (m_v[k][i] && in_r[i]) begin
                m_v[k][i] = 1'b0;
            end
        end
        if (w >= 0) begin
            m_last[k] = (w == 1);
            m_cnt[k][w]++;
            if (in_v[0] && in_v[1]) m_cnt[k][2]++;
        end
    endfunction

    // one clock: called at posedge+1 with inputs set; returns at the next posedge+1
    task automatic step();
        int          w;
        logic [75:0] ew;
        logic [1:0]  er;
        #3;
        for (int k = 0; k < 2; k++) begin
            w = model_grant(k);
            m_win[k] = w;
            er = {w == 1, w == 0};
            ew = (w < 0) ? 76'd0 : {in_op[w], in_opi[w], in_f3[w], in_f7[w], in_a[w], in_b[w]};
            s_rdy[k] = o_rdy[k];
            chk("rq_ready", k, 76'(o_rdy[k]), 76'(er));
            chk("alu_bus", k, o_alu[k], ew);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            model_update(k);
            chk("rs_valid", k, 76'(o_rsv[k]), 76'({m_v[k][1], m_v[k][0]}));
            chk("rs0_data", k, 76'(o_rsd[k][0]), 76'(m_d[k][0]));
            chk("rs1_data", k, 76'(o_rsd[k][1]), 76'(m_d[k][1]));
        end
    endtask

    task automatic set_rq(int i, logic v, logic [2:0] f3, logic [6:0] f7, logic [31:0] a, logic [31:0] b);
        in_v[i]   = v;
        in_op[i]  = 1'b1;
        in_opi[i] = 1'b0;
        in_f3[i]  = f3;
        in_f7[i]  = f7;
        in_a[i]   = a;
        in_b[i]   = b;
    endtask

    typedef struct {
        logic        v0, v1, r0, r1;
        logic [2:0]  f3_0;
        logic [6:0]  f7_0;
        logic [31:0] a0, b0;
        logic [2:0]  f3_1;
        logic [6:0]  f7_1;
        logic [31:0] a1, b1;
        logic [1:0]  e_rdy;
        logic [1:0]  e_v;
        logic [31:0] e_d0, e_d1;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // rows run straight after reset on the round-robin instance
        tbl[0]  = '{1, 1, 1, 1, 3'd0, 7'h20, 32'd10, 32'd4, 3'd4, 7'h00, 32'hF0, 32'h0F, 2'b01, 2'b01, 32'd6, 32'd0};
        tbl[1]  = '{1, 1, 1, 1, 3'd0, 7'h20, 32'd10, 32'd4, 3'd4, 7'h00, 32'hF0, 32'h0F, 2'b10, 2'b10, 32'd6, 32'hFF};
        tbl[2]  = '{1, 1, 1, 1, 3'd0, 7'h20, 32'd10, 32'd4, 3'd4, 7'h00, 32'hF0, 32'h0F, 2'b01, 2'b01, 32'd6, 32'hFF};
        tbl[3]  = '{1, 1, 1, 1, 3'd0, 7'h20, 32'd10, 32'd4, 3'd4, 7'h00, 32'hF0, 32'h0F, 2'b10, 2'b10, 32'd6, 32'hFF};
        tbl[4]  = '{0, 0, 1, 1, 3'd0, 7'h20, 32'd10, 32'd4, 3'd4, 7'h00, 32'hF0, 32'h0F, 2'b00, 2'b00, 32'd6, 32'hFF};
        tbl[5]  = '{1, 0, 1, 1, 3'd0, 7'h00, 32'd5, 32'd3, 3'd4, 7'h00, 32'hF0, 32'h0F, 2'b01, 2'b01, 32'd8, 32'hFF};
        tbl[6]  = '{0, 0, 1, 1, 3'd0, 7'h00, 32'd5, 32'd3, 3'd4, 7'h00, 32'hF0, 32'h0F, 2'b00, 2'b00, 32'd8, 32'hFF};
        tbl[7]  = '{0, 1, 1, 1, 3'd0, 7'h00, 32'd5, 32'd3, 3'd0, 7'h00, 32'h64, 32'hC8, 2'b10, 2'b10, 32'd8, 32'h12C};
        tbl[8]  = '{0, 1, 1, 0, 3'd0, 7'h00, 32'd5, 32'd3, 3'd7, 7'h00, 32'hFF, 32'h0F, 2'b00, 2'b10, 32'd8, 32'h12C};
        tbl[9]  = '{0, 1, 1, 1, 3'd0, 7'h00, 32'd5, 32'd3, 3'd7, 7'h00, 32'hFF, 32'h0F, 2'b10, 2'b10, 32'd8, 32'h0F};
        tbl[10] = '{1, 1, 1, 1, 3'd6, 7'h00, 32'h30, 32'h03, 3'd3, 7'h00, 32'd1, 32'd2, 2'b01, 2'b01, 32'h33, 32'h0F};

        in_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_rq(i, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0);
            in_r[i] = 1'b1;
            model_reset(i);
        end
        @(posedge clk);
        #1;
        // reset state: nothing granted, slots empty and zero
        step();
        in_rst = 1'b0;

        for (int n = 0; n < 11; n++) begin
            set_rq(0, tbl[n].v0, tbl[n].f3_0, tbl[n].f7_0, tbl[n].a0, tbl[n].b0);
            set_rq(1, tbl[n].v1, tbl[n].f3_1, tbl[n].f7_1, tbl[n].a1, tbl[n].b1);
            in_r[0] = tbl[n].r0;
            in_r[1] = tbl[n].r1;
            step();
            chk("tbl_rdy", n, 76'(s_rdy[0]), 76'(tbl[n].e_rdy));
            chk("tbl_rsv", n, 76'(o_rsv[0]), 76'(tbl[n].e_v));
            chk("tbl_rs0", n, 76'(o_rsd[0][0]), 76'(tbl[n].e_d0));
            chk("tbl_rs1", n, 76'(o_rsd[0][1]), 76'(tbl[n].e_d1));
        end

        // backpressure on requester 0: result held, next request waits, then refills with no bubble
        set_rq(0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0);
        set_rq(1, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0);
        in_r[0] = 1'b1;
        in_r[1] = 1'b1;
        step();
        set_rq(0, 1'b1, 3'd0, 7'h00, 32'd7, 32'd1);
        in_r[0] = 1'b0;
        step();
        chk("bp_acc", 0, 76'(s_rdy[0][0]), 76'd1);
        chk("bp_data8", 0, 76'(o_rsd[0][0]), 76'd8);
        set_rq(0, 1'b1, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1);
        for (int n = 0; n < 2; n++) begin
            step();
            chk("bp_wait", n, 76'(s_rdy[0][0]), 76'd0);
            chk("bp_hold_v", n, 76'(o_rsv[0][0]), 76'd1);
            chk("bp_hold_d", n, 76'(o_rsd[0][0]), 76'd8);
        end
        in_r[0] = 1'b1;
        step();
        chk("bp_refill_rdy", 0, 76'(s_rdy[0][0]), 76'd1);
        chk("bp_refill_v", 0, 76'(o_rsv[0][0]), 76'd1);
        chk("bp_refill_d", 0, 76'(o_rsd[0][0]), 76'd1);
        set_rq(0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0);
        step();
        chk("bp_drain", 0, 76'(o_rsv[0][0]), 76'd0);

        // fixed priority: requester 1 waits while requester 0 keeps asking
        set_rq(0, 1'b1, 3'd0, 7'h00, 32'd1, 32'd2);
        set_rq(1, 1'b1, 3'd1, 7'h00, 32'd1, 32'd4);
        for (int n = 0; n < 4; n++) begin
            step();
            chk("fp_hold", n, 76'(s_rdy[1]), 76'(2'b01));
        end
        set_rq(0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0);
        step();
        chk("fp_rq1", 0, 76'(s_rdy[1]), 76'(2'b10));
        chk("fp_rq1_d", 0, 76'(o_rsd[1][1]), 76'd16);

        // reset lands on the cycle requester 1 is granted: the result is dropped
        set_rq(1, 1'b1, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
        in_rst = 1'b1;
        step();
        chk("rst_grant", 0, 76'(s_rdy[0]), 76'(2'b10));
        chk("rst_rs1v", 0, 76'(o_rsv[0][1]), 76'd0);
        chk("rst_rs1d", 0, 76'(o_rsd[0][1]), 76'd0);
        in_rst = 1'b0;
        set_rq(0, 1'b1, 3'd0, 7'h00, 32'd2, 32'd2);
        step();
        chk("rst_last", 0, 76'(s_rdy[0]), 76'(2'b01));

`ifdef ALU_SHARE_ARB_STATS_EN
        // three round-robin conflicts from reset: grants go 0,1,0
        in_rst = 1'b1;
        step();
        in_rst = 1'b0;
        for (int n = 0; n < 3; n++) step();
        chk("st_conflict", 0, 76'(st_cf[0]), 76'd3);
        chk("st_grant0", 0, 76'(st_g0[0]), 76'd2);
        chk("st_grant1", 0, 76'(st_g1[0]), 76'd1);
`endif

        // random traffic against the model on both instances
        for (int n = 0; n < 1500; n++) begin
            in_rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 2; i++) begin
                in_v[i]   = ($urandom_range(0, 9) < 6);
                in_r[i]   = ($urandom_range(0, 9) < 7);
                in_op[i]  = 1'($urandom_range(0, 1));
                in_opi[i] = 1'($urandom_range(0, 1));
                in_f3[i]  = 3'($urandom_range(0, 7));
                in_f7[i]  = $urandom_range(0, 1) ? 7'h20 : 7'h00;
                in_a[i]   = $urandom;
                in_b[i]   = $urandom;
            end
            step();
        end

`ifdef ALU_SHARE_ARB_STATS_EN
        for (int k = 0; k < 2; k++) begin
            chk("rnd_grant0", k, 76'(st_g0[k]), 76'(m_cnt[k][0]));
            chk("rnd_grant1", k, 76'(st_g1[k]), 76'(m_cnt[k][1]));
            chk("rnd_conflict", k, 76'(st_cf[k]), 76'(m_cnt[k][2]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
